// File: rtl/rsa_multicore_ctrl.sv
// Arm command front-end for N_CORES Montgomery cores: per-core operand banks, results, timeouts, status word.
// New state one cycle after cmd_valid; inbound/outbound beats are valid/ready and a command completes via done/done_read.
module rsa_multicore_ctrl #(
  parameter int TX_SIZE   = 1024,
  parameter int OP_W      = 512,
  parameter int N_CORES   = 2,
  parameter int TIMEOUT_W = 24
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [31:0]               arm_to_fpga_cmd,
  input  logic                      arm_to_fpga_cmd_valid,
  output logic                      fpga_to_arm_done,
  input  logic                      fpga_to_arm_done_read,
  input  logic                      arm_to_fpga_data_valid,
  output logic                      arm_to_fpga_data_ready,
  input  logic [TX_SIZE-1:0]        arm_to_fpga_data,
  output logic                      fpga_to_arm_data_valid,
  input  logic                      fpga_to_arm_data_ready,
  output logic [TX_SIZE-1:0]        fpga_to_arm_data,
  output logic [N_CORES-1:0]        core_resetn,
  output logic [N_CORES-1:0]        core_start,
  output logic [N_CORES-1:0]        core_mult_en,
  output logic [N_CORES*OP_W-1:0]   core_modulus,
  output logic [N_CORES*OP_W-1:0]   core_rsq,
  output logic [N_CORES*OP_W-1:0]   core_x,
  output logic [N_CORES*OP_W-1:0]   core_exp,
  output logic [N_CORES*OP_W-1:0]   core_rmodm,
  input  logic [N_CORES-1:0]        core_done,
  input  logic [N_CORES*OP_W-1:0]   core_result,
  output logic [3:0]                leds
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_LAUNCH = 3'd2, S_WAIT_RES = 3'd3, S_WRITE = 3'd4, S_DONE = 3'd5
  } state_t;

  localparam logic [2:0] OP_MONT = 3'd1, OP_LD_MOD = 3'd2, OP_LD_RSQ_X = 3'd3, OP_LD_EXP_RM = 3'd4;
  localparam logic [2:0] OP_READ = 3'd5, OP_EXP = 3'd6;
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = 1;
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t                 r_state, w_next;
  logic [2:0]             r_op, r_idx;
  logic                   r_err_last;
  logic [N_CORES-1:0]     r_busy, r_done, r_tmo, r_start, r_mult_en, r_core_resetn;
  logic [OP_W-1:0]        r_mod [N_CORES];
  logic [OP_W-1:0]        r_rsq [N_CORES];
  logic [OP_W-1:0]        r_x [N_CORES];
  logic [OP_W-1:0]        r_exp [N_CORES];
  logic [OP_W-1:0]        r_rmodm [N_CORES];
  logic [OP_W-1:0]        r_result [N_CORES];
  logic [TIMEOUT_W-1:0]   r_cnt [N_CORES];
  logic [TX_SIZE-1:0]     r_out_data;

  logic [2:0]             w_cmd_op, w_cmd_idx;
  logic [7:0]             w_busy8, w_done8, w_tmo8;
  logic [N_CORES-1:0]     w_sel;
  logic                   w_cmd_err, w_is_load, w_is_launch, w_ld_fire, w_wr_fire;
  logic [31:0]            w_status;
  logic [OP_W-1:0]        w_res_sel;
  logic [TX_SIZE-1:0]     w_wr_word;
  logic                   w_unused;

  assign w_cmd_op    = arm_to_fpga_cmd[2:0];
  assign w_cmd_idx   = arm_to_fpga_cmd[6:4];
  assign w_unused    = ^{arm_to_fpga_cmd, arm_to_fpga_data};
  assign w_is_load   = (w_cmd_op == OP_LD_MOD) || (w_cmd_op == OP_LD_RSQ_X) || (w_cmd_op == OP_LD_EXP_RM);
  assign w_is_launch = (w_cmd_op == OP_MONT) || (w_cmd_op == OP_EXP);
  assign w_cmd_err   = (w_cmd_op == 3'd0) || (32'(w_cmd_idx) >= N_CORES) ||
                       ((w_is_load || w_is_launch) && w_busy8[w_cmd_idx]);
  assign w_ld_fire   = (r_state == S_LOAD) && arm_to_fpga_data_valid;
  assign w_wr_fire   = (r_state == S_WRITE) && fpga_to_arm_data_ready;
  assign w_status    = {7'd0, r_err_last, w_tmo8, w_done8, w_busy8};

  // Bitmaps widened to 8 so unimplemented cores read as zero
  always_comb begin
    w_busy8 = '0;
    w_done8 = '0;
    w_tmo8  = '0;
    w_busy8[N_CORES-1:0] = r_busy;
    w_done8[N_CORES-1:0] = r_done;
    w_tmo8[N_CORES-1:0]  = r_tmo;
  end

  always_comb begin
    w_res_sel = '0;
    for (int i = 0; i < N_CORES; i++)
      if (w_sel[i]) w_res_sel = r_result[i];
  end

  // Only READ reaches WRITE through WAIT_RES; STATUS enters straight from IDLE
  always_comb begin
    w_wr_word = '0;
    w_wr_word[TX_SIZE-1 -: 32] = w_status;
    if (r_state == S_WAIT_RES) w_wr_word[OP_W-1:0] = w_res_sel;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (arm_to_fpga_cmd_valid) begin
          if (w_cmd_err)                  w_next = S_DONE;
          else if (w_is_load)             w_next = S_LOAD;
          else if (w_is_launch)           w_next = S_LAUNCH;
          else if (w_cmd_op == OP_READ)   w_next = S_WAIT_RES;
          else                            w_next = S_WRITE;
        end
      S_LOAD:     if (arm_to_fpga_data_valid) w_next = S_DONE;
      S_LAUNCH:   w_next = S_DONE;
      S_WAIT_RES: if (!w_busy8[r_idx]) w_next = S_WRITE;
      S_WRITE:    if (fpga_to_arm_data_ready) w_next = S_DONE;
      S_DONE:     if (fpga_to_arm_done_read) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_op       <= '0;
      r_idx      <= '0;
      r_err_last <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (r_state == S_IDLE && arm_to_fpga_cmd_valid) begin
        r_op       <= w_cmd_op;
        r_idx      <= w_cmd_idx;
        r_err_last <= w_cmd_err;
      end
      if (w_next == S_WRITE && r_state != S_WRITE) r_out_data <= w_wr_word;
    end
  end

  // Per-core engine; launch, load and read-clear only touch the selected core, which is never busy then
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_busy        <= '0;
      r_done        <= '0;
      r_tmo         <= '0;
      r_start       <= '0;
      r_mult_en     <= '0;
      r_core_resetn <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        r_mod[i] <= '0; r_rsq[i] <= '0; r_x[i] <= '0; r_exp[i] <= '0; r_rmodm[i] <= '0;
        r_result[i] <= '0; r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if (r_busy[i]) begin
          if (core_done[i]) begin
            r_result[i] <= core_result[i*OP_W +: OP_W];
            r_busy[i]   <= 1'b0;
            r_done[i]   <= 1'b1;
            r_start[i]  <= 1'b0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_ONE;
            if (r_cnt[i] == CNT_LAST) begin
              r_busy[i]        <= 1'b0;
              r_tmo[i]         <= 1'b1;
              r_start[i]       <= 1'b0;
              r_core_resetn[i] <= 1'b0;
            end
          end
        end else begin
          r_core_resetn[i] <= 1'b0;
        end
        if (w_sel[i]) begin
          if (w_ld_fire) begin
            case (r_op)
              OP_LD_MOD:    r_mod[i] <= arm_to_fpga_data[OP_W-1:0];
              OP_LD_RSQ_X:  begin
                r_rsq[i] <= arm_to_fpga_data[OP_W-1:0];
                r_x[i]   <= arm_to_fpga_data[2*OP_W-1:OP_W];
              end
              OP_LD_EXP_RM: begin
                r_exp[i]   <= arm_to_fpga_data[OP_W-1:0];
                r_rmodm[i] <= arm_to_fpga_data[2*OP_W-1:OP_W];
              end
              default: ;
            endcase
          end
          if (r_state == S_LAUNCH) begin
            r_core_resetn[i] <= 1'b1;
            r_mult_en[i]     <= (r_op == OP_MONT);
            r_busy[i]        <= 1'b1;
            r_done[i]        <= 1'b0;
            r_tmo[i]         <= 1'b0;
            r_cnt[i]         <= '0;
            r_start[i]       <= 1'b1;
          end
          if (w_wr_fire && r_op == OP_READ) r_done[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_core
    assign w_sel[g] = (r_idx == 3'(g));
    assign core_modulus[g*OP_W +: OP_W] = r_mod[g];
    assign core_rsq[g*OP_W +: OP_W]     = r_rsq[g];
    assign core_x[g*OP_W +: OP_W]       = r_x[g];
    assign core_exp[g*OP_W +: OP_W]     = r_exp[g];
    assign core_rmodm[g*OP_W +: OP_W]   = r_rmodm[g];
  end

  assign arm_to_fpga_data_ready = (r_state == S_LOAD);
  assign fpga_to_arm_data_valid = (r_state == S_WRITE);
  assign fpga_to_arm_done       = (r_state == S_DONE);
  assign fpga_to_arm_data       = r_out_data;
  assign core_resetn            = r_core_resetn;
  assign core_start             = r_start;
  assign core_mult_en           = r_mult_en;
  assign leds                   = {r_err_last, r_state};

endmodule
